// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op encodings and flag bit positions.
// Imported by alu_core and alu_pipe.
package alu_pkg;

   localparam logic [2:0] ALU_OP_ADD = 3'b000;
   localparam logic [2:0] ALU_OP_SUB = 3'b001;
   localparam logic [2:0] ALU_OP_AND = 3'b010;
   localparam logic [2:0] ALU_OP_OR  = 3'b011;
   localparam logic [2:0] ALU_OP_XOR = 3'b100;
   localparam logic [2:0] ALU_OP_SLL = 3'b101;
   localparam logic [2:0] ALU_OP_SRL = 3'b110;
   localparam logic [2:0] ALU_OP_SRA = 3'b111;

   // Bit positions when the four flags are packed into one vector
   localparam int FLG_COUT = 0;
   localparam int FLG_ZERO = 1;
   localparam int FLG_NEG  = 2;
   localparam int FLG_OVF  = 3;

   function automatic logic is_arith(input logic [2:0] op);
      return (op == ALU_OP_ADD) || (op == ALU_OP_SUB);
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: {op,i0,i1} -> {o,cout,ovf}.
// Ports: op(3), i0/i1(WIDTH) in; o(WIDTH), cout, ovf out.
// Optional macro ALU_PIPE_SAT_EN: signed saturation of ADD/SUB results.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   output logic [WIDTH-1:0] o,
   output logic             cout,
   output logic             ovf
);

   localparam int SW = $clog2(WIDTH);

   logic [SW-1:0]  sh;
   logic [WIDTH:0] add_r;
   logic [WIDTH:0] sub_r;
   logic [WIDTH:0] sll_r;
   logic [WIDTH:0] srl_r;
   logic [WIDTH:0] sra_r;
   logic           add_v;
   logic           sub_v;
   logic           msb_a;

   assign sh    = i1[SW-1:0];
   assign msb_a = i0[WIDTH-1];

   assign add_r = {1'b0, i0} + {1'b0, i1};
   assign sub_r = {1'b0, i0} + {1'b0, ~i1} + (WIDTH+1)'(1);

   assign add_v = (msb_a == i1[WIDTH-1]) &&
                  (add_r[WIDTH-1] != msb_a);
   assign sub_v = (msb_a != i1[WIDTH-1]) &&
                  (sub_r[WIDTH-1] != msb_a);

   // One guard bit beyond the operand catches the last bit shifted out;
   // a zero shift leaves the guard bit at 0.
   assign sll_r = {1'b0, i0} << sh;
   assign srl_r = {i0, 1'b0} >> sh;
   assign sra_r = $unsigned($signed({i0, 1'b0}) >>> sh);

   logic [WIDTH-1:0] res;

   always_comb begin
      res  = '0;
      cout = 1'b0;
      ovf  = 1'b0;
      unique case (op)
         ALU_OP_ADD: begin
            res  = add_r[WIDTH-1:0];
            cout = add_r[WIDTH];
            ovf  = add_v;
         end
         ALU_OP_SUB: begin
            res  = sub_r[WIDTH-1:0];
            cout = sub_r[WIDTH];
            ovf  = sub_v;
         end
         ALU_OP_AND: res = i0 & i1;
         ALU_OP_OR:  res = i0 | i1;
         ALU_OP_XOR: res = i0 ^ i1;
         ALU_OP_SLL: begin
            res  = sll_r[WIDTH-1:0];
            cout = sll_r[WIDTH];
         end
         ALU_OP_SRL: begin
            res  = srl_r[WIDTH:1];
            cout = srl_r[0];
         end
         ALU_OP_SRA: begin
            res  = sra_r[WIDTH:1];
            cout = sra_r[0];
         end
         default: res = '0;
      endcase
   end

`ifdef ALU_PIPE_SAT_EN
   // On overflow the sign of i0 tells the direction for both ADD and SUB:
   // a non-negative i0 can only overflow upward.
   always_comb begin
      o = res;
      if (is_arith(op) && ovf)
         o = msb_a ? {1'b1, {(WIDTH-1){1'b0}}}
                   : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   assign o = res;
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready ports and full backpressure.
// Ports: clk, reset (sync, active-high); in_valid/in_ready, op, i0, i1;
//        out_valid/out_ready, o, cout, zero, neg, ovf; ops_done counter.
// Optional macro ALU_PIPE_SAT_EN (handled in alu_core): signed saturation.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] o,
   output logic             cout,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic [CNT_W-1:0] ops_done
);

   logic             s1_valid;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;

   logic             s1_en;
   logic             s2_en;

   logic [WIDTH-1:0] c_o;
   logic             c_cout;
   logic             c_ovf;
   logic [3:0]       c_flg;

   // in_ready is combinational on out_ready: a full pipe refills on the
   // same edge the result leaves, so stall release never inserts a bubble.
   assign s2_en    = !out_valid || out_ready;
   assign s1_en    = !s1_valid || s2_en;
   assign in_ready = s1_en && !reset;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op   (s1_op),
      .i0   (s1_a),
      .i1   (s1_b),
      .o    (c_o),
      .cout (c_cout),
      .ovf  (c_ovf)
   );

   always_comb begin
      c_flg           = '0;
      c_flg[FLG_COUT] = c_cout;
      c_flg[FLG_ZERO] = (c_o == '0);
      c_flg[FLG_NEG]  = c_o[WIDTH-1];
      c_flg[FLG_OVF]  = c_ovf;
   end

   // Stage S1: operand capture
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_op    <= ALU_OP_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (s1_en) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= op;
            s1_a  <= i0;
            s1_b  <= i1;
         end
      end
   end

   // Stage S2: result and flags
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         o         <= '0;
         cout      <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
      end else if (s2_en) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            o    <= c_o;
            cout <= c_flg[FLG_COUT];
            zero <= c_flg[FLG_ZERO];
            neg  <= c_flg[FLG_NEG];
            ovf  <= c_flg[FLG_OVF];
         end
      end
   end

   // Output handshake counter, wraps naturally at all-ones
   always_ff @(posedge clk) begin
      if (reset)
         ops_done <= '0;
      else if (out_valid && out_ready)
         ops_done <= ops_done + CNT_W'(1);
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=16, CNT_W=16).
// Honors ALU_PIPE_SAT_EN when choosing expected ADD/SUB overflow results.
module tb_alu_pipe;

   localparam logic [2:0] ADD = 3'b000;
   localparam logic [2:0] SUB = 3'b001;
   localparam logic [2:0] AND = 3'b010;
   localparam logic [2:0] OR  = 3'b011;
   localparam logic [2:0] XOR = 3'b100;
   localparam logic [2:0] SLL = 3'b101;
   localparam logic [2:0] SRL = 3'b110;
   localparam logic [2:0] SRA = 3'b111;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [15:0] i0;
   logic [15:0] i1;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] o;
   logic        cout;
   logic        zero;
   logic        neg;
   logic        ovf;
   logic [15:0] ops_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_pipe #(
      .WIDTH (16),
      .CNT_W (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .i0        (i0),
      .i1        (i1),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .o         (o),
      .cout      (cout),
      .zero      (zero),
      .neg       (neg),
      .ovf       (ovf),
      .ops_done  (ops_done)
   );

   // Issue one op from an idle pipe, wait (bounded) for its result and
   // let the result handshake. Flags returned as {ovf,neg,zero,cout}.
   task automatic run_op(input logic [2:0] f, input logic [15:0] a,
                         input logic [15:0] b, output logic [15:0] r,
                         output logic [3:0] fl, output int lat);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      op        = f;
      i0        = a;
      i1        = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r  = o;
      fl = {ovf, neg, zero, cout};
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset;
      reset    = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = ADD;
      i0        = '0;
      i1        = '0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, o, cout, zero, neg, ovf} !== 21'd0) begin
         errors++;
         $display("FAIL reset_out: got v=%b o=%h f=%b%b%b%b want all 0",
                  out_valid, o, cout, zero, neg, ovf);
      end
      checks++;
      if (ops_done !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %h want 0000", ops_done);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdy_in: got %b want 0", in_ready);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_rdy_after: got %b want 1", in_ready);
      end
      @(posedge clk);
      #1;
   endtask

   // Row: {op, i0, i1, o, {ovf,neg,zero,cout}}
   task automatic test_add;
      logic [54:0] tv [3];
      logic [15:0] r;
      logic [3:0]  fl;
      int          lat;
      tv[0] = {ADD, 16'haa55, 16'h55aa, 16'hffff, 4'b0100};
      tv[1] = {ADD, 16'hffff, 16'h0001, 16'h0000, 4'b0011};
`ifdef ALU_PIPE_SAT_EN
      tv[2] = {ADD, 16'h0001, 16'h7fff, 16'h7fff, 4'b1000};
`else
      tv[2] = {ADD, 16'h0001, 16'h7fff, 16'h8000, 4'b1100};
`endif
      for (int k = 0; k < 3; k++) begin
         run_op(tv[k][54:52], tv[k][51:36], tv[k][35:20], r, fl, lat);
         checks++;
         if ({r, fl} !== tv[k][19:0]) begin
            errors++;
            $display("FAIL add_%0d: got o=%h f=%b want o=%h f=%b",
                     k, r, fl, tv[k][19:4], tv[k][3:0]);
         end
         checks++;
         if (lat !== 2) begin
            errors++;
            $display("FAIL add_lat_%0d: got %0d want 2", k, lat);
         end
      end
      checks++;
      if (ops_done !== 16'd3) begin
         errors++;
         $display("FAIL add_cnt: got %0d want 3", ops_done);
      end
   endtask

   task automatic test_sub;
      logic [54:0] tv [4];
      logic [15:0] r;
      logic [3:0]  fl;
      int          lat;
      tv[0] = {SUB, 16'h0001, 16'h7fff, 16'h8002, 4'b0100};
      tv[1] = {SUB, 16'h0000, 16'h0000, 16'h0000, 4'b0011};
`ifdef ALU_PIPE_SAT_EN
      tv[2] = {SUB, 16'h8000, 16'h0001, 16'h8000, 4'b1101};
`else
      tv[2] = {SUB, 16'h8000, 16'h0001, 16'h7fff, 4'b1001};
`endif
      tv[3] = {SUB, 16'h0005, 16'h0003, 16'h0002, 4'b0001};
      for (int k = 0; k < 4; k++) begin
         run_op(tv[k][54:52], tv[k][51:36], tv[k][35:20], r, fl, lat);
         checks++;
         if ({r, fl} !== tv[k][19:0] || lat !== 2) begin
            errors++;
            $display("FAIL sub_%0d: got o=%h f=%b lat=%0d want o=%h f=%b lat=2",
                     k, r, fl, lat, tv[k][19:4], tv[k][3:0]);
         end
      end
   endtask

   task automatic test_shift;
      logic [54:0] tv [7];
      logic [15:0] r;
      logic [3:0]  fl;
      int          lat;
      tv[0] = {SLL, 16'h0001, 16'h000f, 16'h8000, 4'b0100};
      tv[1] = {SRA, 16'h8000, 16'h0004, 16'hf800, 4'b0100};
      tv[2] = {SRL, 16'h0003, 16'h0001, 16'h0001, 4'b0001};
      tv[3] = {SLL, 16'h8001, 16'h0001, 16'h0002, 4'b0001};
      tv[4] = {SLL, 16'h1234, 16'h0000, 16'h1234, 4'b0000};
      tv[5] = {SRL, 16'h00f0, 16'h0014, 16'h000f, 4'b0000};
      tv[6] = {SRA, 16'h7ff8, 16'h0004, 16'h07ff, 4'b0001};
      for (int k = 0; k < 7; k++) begin
         run_op(tv[k][54:52], tv[k][51:36], tv[k][35:20], r, fl, lat);
         checks++;
         if ({r, fl} !== tv[k][19:0] || lat !== 2) begin
            errors++;
            $display("FAIL shift_%0d: got o=%h f=%b lat=%0d want o=%h f=%b lat=2",
                     k, r, fl, lat, tv[k][19:4], tv[k][3:0]);
         end
      end
   endtask

   task automatic test_logic;
      logic [54:0] tv [4];
      logic [15:0] r;
      logic [3:0]  fl;
      int          lat;
      tv[0] = {AND, 16'hf0f0, 16'hff00, 16'hf000, 4'b0100};
      tv[1] = {OR,  16'h0f00, 16'h00f0, 16'h0ff0, 4'b0000};
      tv[2] = {XOR, 16'haaaa, 16'haaaa, 16'h0000, 4'b0010};
      tv[3] = {XOR, 16'h8001, 16'h0001, 16'h8000, 4'b0100};
      for (int k = 0; k < 4; k++) begin
         run_op(tv[k][54:52], tv[k][51:36], tv[k][35:20], r, fl, lat);
         checks++;
         if ({r, fl} !== tv[k][19:0] || lat !== 2) begin
            errors++;
            $display("FAIL logic_%0d: got o=%h f=%b lat=%0d want o=%h f=%b lat=2",
                     k, r, fl, lat, tv[k][19:4], tv[k][3:0]);
         end
      end
   endtask

   // 16 ADDs k+0x100 streamed with out_ready low for cycles 6..8
   task automatic test_back_to_back;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      logic        rdy_low = 1'b0;
      logic        stalled = 1'b0;
      logic [15:0] held = '0;
      logic        acc;
      pulse_reset();
      while (got < 16 && cyc < 80) begin
         out_ready = !(cyc >= 6 && cyc < 9);
         in_valid  = (sent < 16);
         op        = ADD;
         i0        = 16'(sent);
         i1        = 16'h0100;
         #1;
         if (!in_ready) rdy_low = 1'b1;
         if (out_valid && !out_ready) begin
            if (stalled) begin
               checks++;
               if (o !== held) begin
                  errors++;
                  $display("FAIL b2b_hold: got %h want %h", o, held);
               end
            end
            held    = o;
            stalled = 1'b1;
         end else begin
            stalled = 1'b0;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (o !== 16'(got) + 16'h0100) begin
               errors++;
               $display("FAIL b2b_res_%0d: got %h want %h",
                        got, o, 16'(got) + 16'h0100);
            end
            got++;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) sent++;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got !== 16) begin
         errors++;
         $display("FAIL b2b_count: got %0d results want 16", got);
      end
      checks++;
      if (rdy_low !== 1'b1) begin
         errors++;
         $display("FAIL b2b_backpressure: in_ready low seen=%b want 1", rdy_low);
      end
      checks++;
      if (ops_done !== 16'd16) begin
         errors++;
         $display("FAIL b2b_ops_done: got %0d want 16", ops_done);
      end
      checks++;
      if (cyc !== 21) begin
         errors++;
         $display("FAIL b2b_cycles: got %0d want 21", cyc);
      end
   endtask

   // Two ops held in the pipe by backpressure, then reset
   task automatic test_reset_midflight;
      logic seen = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      op        = ADD;
      i0        = 16'h1111;
      i1        = 16'h2222;
      @(posedge clk);
      #1;
      i0 = 16'h3333;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || o !== 16'h3333) begin
         errors++;
         $display("FAIL mid_fill: got v=%b o=%h want v=1 o=3333", out_valid, o);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, o, ops_done, in_ready} !== 34'd0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b o=%h cnt=%h rdy=%b want all 0",
                  out_valid, o, ops_done, in_ready);
      end
      reset     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || ops_done !== 16'd0) begin
         errors++;
         $display("FAIL mid_stale: got stale=%b cnt=%0d want stale=0 cnt=0",
                  seen, ops_done);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_shift();
      test_logic();
      test_back_to_back();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
